// File: rtl/audio_fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_fir_pkg
// Desc     : Shared constants, LPR coefficient table, Q10 dequantizer and
//            FSM state type for the audio FIR decimator.
// Revision : 1.0 - initial release
// ============================================================================
package audio_fir_pkg;

  localparam int TAPS  = 32;
  localparam int DECIM = 8;
  localparam int QBITS = 10;
  localparam int TAP_W = $clog2(TAPS);
  localparam int DEC_W = $clog2(DECIM);

  localparam logic signed [31:0] AUDIO_MAX = 32'sd32767;
  localparam logic signed [31:0] AUDIO_MIN = -32'sd32768;
  localparam logic signed [63:0] DEQ_BIAS  = 64'((1 << QBITS) - 1);

  // Symmetric low-pass taps, Q10; DC gain is the sum of all entries.
  localparam logic signed [31:0] AUDIO_LPR_COEFFS [TAPS] = '{
    -32'sd2,  -32'sd3,  -32'sd4,  -32'sd3,  32'sd0,   32'sd6,   32'sd14,  32'sd24,
     32'sd36,  32'sd48,  32'sd60,  32'sd70,  32'sd78,  32'sd84,  32'sd88,  32'sd90,
     32'sd90,  32'sd88,  32'sd84,  32'sd78,  32'sd70,  32'sd60,  32'sd48,  32'sd36,
     32'sd24,  32'sd14,  32'sd6,   32'sd0,  -32'sd3,  -32'sd4,  -32'sd3,  -32'sd2
  };

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    MAC    = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Q10 product back to Q10, rounding toward zero rather than toward -inf.
  function automatic logic signed [31:0] dequantize(input logic signed [63:0] prod);
    logic signed [63:0] biased;
    biased = prod[63] ? (prod + DEQ_BIAS) : prod;
    return 32'(biased >>> QBITS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_fir_decim_mac.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_unit
// Desc     : Signed 32x32 multiply, Q10 dequantize and 32-bit accumulate.
//            AUDIO_FIR_SAT_EN selects saturating instead of wrapping adds.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_unit
  import audio_fir_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] sample,
  input  logic [31:0] coef,
  output logic [31:0] acc_next
);

  logic [31:0]        r_acc;
  logic signed [63:0] w_prod;
  logic [31:0]        w_term;

  assign w_prod = $signed({{32{sample[31]}}, sample}) * $signed({{32{coef[31]}}, coef});
  assign w_term = dequantize(w_prod);

`ifdef AUDIO_FIR_SAT_EN
  logic [32:0] w_sum;
  assign w_sum = {r_acc[31], r_acc} + {w_term[31], w_term};

  // Differing top two bits of the 33-bit sum mark a signed overflow.
  always_comb begin
    acc_next = w_sum[31:0];
    if (w_sum[32] != w_sum[31]) begin
      acc_next = w_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end
`else
  assign acc_next = r_acc + w_term;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= acc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_fir_decim.sv
`default_nettype none
// ============================================================================
// Module   : audio_fir_decim
// Desc     : Q10 low-pass FIR with decimation by DECIM; one MAC per cycle.
//            Define AUDIO_FIR_SAT_EN for saturating accumulate and 16-bit clamp.
// Revision : 1.0 - initial release
// ============================================================================
module audio_fir_decim
  import audio_fir_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        input_fifo_empty,
  output logic        input_rd_en,
  input  logic [31:0] sample_in,
  output logic [31:0] audio_out,
  output logic        wr_en_out,
  input  logic        out_fifo_full
);

  state_t           r_state;
  state_t           w_next_state;
  logic [31:0]      r_shift [TAPS];
  logic [DEC_W-1:0] r_dec_cnt;
  logic [TAP_W-1:0] r_tap_idx;
  logic [31:0]      r_audio;

  logic             w_pop;
  logic             w_push;
  logic             w_mac_en;
  logic             w_block_done;
  logic             w_last_tap;
  logic [31:0]      w_tap_sample;
  logic [31:0]      w_tap_coef;
  logic [31:0]      w_acc_next;
  logic [31:0]      w_audio_next;

  assign w_last_tap   = (r_tap_idx == TAP_W'(TAPS - 1));
  assign w_block_done = w_pop && (r_dec_cnt == DEC_W'(DECIM - 1));
  assign w_tap_sample = r_shift[r_tap_idx];
  assign w_tap_coef   = AUDIO_LPR_COEFFS[r_tap_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ACCEPT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACCEPT:  if (w_block_done)   w_next_state = MAC;
      MAC:     if (w_last_tap)     w_next_state = OUTPUT;
      OUTPUT:  if (!out_fifo_full) w_next_state = ACCEPT;
      default:                     w_next_state = ACCEPT;
    endcase
  end

  // Strobes are gated by reset so nothing leaks out while it is held.
  always_comb begin
    w_pop    = reset && (r_state == ACCEPT) && !input_fifo_empty;
    w_mac_en = (r_state == MAC);
    w_push   = reset && (r_state == OUTPUT) && !out_fifo_full;
  end

  assign input_rd_en = w_pop;
  assign wr_en_out   = w_push;
  assign audio_out   = r_audio;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) r_shift[i] <= '0;
      r_dec_cnt <= '0;
      r_tap_idx <= '0;
      r_audio   <= '0;
    end else begin
      if (w_pop) begin
        r_shift[0] <= sample_in;
        for (int i = 1; i < TAPS; i++) r_shift[i] <= r_shift[i-1];
        r_dec_cnt <= w_block_done ? '0 : r_dec_cnt + DEC_W'(1);
      end
      if (w_block_done) begin
        r_tap_idx <= '0;
      end else if (w_mac_en) begin
        r_tap_idx <= r_tap_idx + TAP_W'(1);
      end
      if (w_mac_en && w_last_tap) begin
        r_audio <= w_audio_next;
      end
    end
  end

  fir_mac_unit u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_block_done),
    .en       (w_mac_en),
    .sample   (w_tap_sample),
    .coef     (w_tap_coef),
    .acc_next (w_acc_next)
  );

`ifdef AUDIO_FIR_SAT_EN
  always_comb begin
    w_audio_next = w_acc_next;
    if ($signed(w_acc_next) > AUDIO_MAX) w_audio_next = AUDIO_MAX;
    else if ($signed(w_acc_next) < AUDIO_MIN) w_audio_next = AUDIO_MIN;
  end
`else
  assign w_audio_next = w_acc_next;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_fir_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_fir_decim
// Desc     : Self-checking bench for audio_fir_decim with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_fir_decim;

  localparam int NT = 32;
  localparam int ND = 8;
  localparam int QB = 10;

  int coef [NT] = '{-2, -3, -4, -3, 0, 6, 14, 24, 36, 48, 60, 70, 78, 84, 88, 90,
                    90, 88, 84, 78, 70, 60, 48, 36, 24, 14, 6, 0, -3, -4, -3, -2};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        input_fifo_empty = 1'b1;
  logic        input_rd_en;
  logic [31:0] sample_in = '0;
  logic [31:0] audio_out;
  logic        wr_en_out;
  logic        out_fifo_full = 1'b0;

  audio_fir_decim dut (
    .clk              (clk),
    .reset            (reset),
    .input_fifo_empty (input_fifo_empty),
    .input_rd_en      (input_rd_en),
    .sample_in        (sample_in),
    .audio_out        (audio_out),
    .wr_en_out        (wr_en_out),
    .out_fifo_full    (out_fifo_full)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc = 0;
  int  pend_cyc = 0;
  bit  busy = 0, full_seen = 0, pop_flag = 0, phase = 0;
  int  stall_mode = 0;
  bit  full_force = 0, full_rand = 0;
  int  hist[$], exp_q[$], got_q[$], stim_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output implied by the samples popped since reset: newest sample meets coef[0].
  function automatic int model_out();
    int     acc = 0;
    longint p, d, s;
    int     x, term;
    for (int i = 0; i < NT; i++) begin
      x = (hist.size() - 1 - i >= 0) ? hist[hist.size() - 1 - i] : 0;
      p = longint'(x) * longint'(coef[i]);
      d = (p < 0) ? -((-p) >>> QB) : (p >>> QB);
      term = int'(d);
`ifdef AUDIO_FIR_SAT_EN
      s = longint'(acc) + longint'(term);
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      acc = int'(s);
`else
      s = 0;
      acc = acc + term;
`endif
    end
`ifdef AUDIO_FIR_SAT_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`endif
    return acc;
  endfunction

  function automatic int rand_sample();
    int r;
    case ($urandom_range(0, 2))
      0:       r = int'($urandom_range(0, 8191)) - 4096;
      1:       r = int'($urandom);
      default: r = 1024 * (int'($urandom_range(0, 6)) - 3);
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Source/sink FIFO models.
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_flag) begin
      if (stim_q.size() > 0) void'(stim_q.pop_front());
      pop_flag = 0;
    end
    phase = ~phase;
    input_fifo_empty = (stim_q.size() == 0) ||
                       (stall_mode == 1 && phase) ||
                       (stall_mode == 2 && $urandom_range(0, 3) == 0);
    sample_in     = (stim_q.size() > 0) ? stim_q[0] : $urandom;
    out_fifo_full = full_rand ? ($urandom_range(0, 7) == 0) : full_force;
  end

  // Compare process: protocol and data checked against the model every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_rd_en", input_rd_en, 0);
      chk("reset_wr_en", wr_en_out, 0);
      chk("reset_audio", audio_out, 0);
      hist.delete(); exp_q.delete(); got_q.delete();
      busy = 0; full_seen = 0;
    end else begin
      if (input_rd_en) begin
        chk("rd_while_empty", input_fifo_empty, 0);
        chk("pop_while_busy", busy, 0);
        pop_flag = 1;
        hist.push_back(int'(sample_in));
        if (hist.size() % ND == 0) begin
          exp_q.push_back(model_out());
          busy = 1; full_seen = 0; pend_cyc = cyc;
        end
      end
      if (out_fifo_full) begin
        chk("wr_while_full", wr_en_out, 0);
        if (busy) full_seen = 1;
      end
      if (wr_en_out) begin
        chk("wr_without_block", busy, 1);
        if (exp_q.size() > 0) chk("audio_out", longint'($signed(audio_out)), exp_q.pop_front());
        if (busy && !full_seen) chk("latency", cyc - pend_cyc, NT + 1);
        got_q.push_back(int'(audio_out));
        busy = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 0;
    stim_q.delete();
    pop_flag = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1;
  endtask

  task automatic wait_outputs(input int n, input int budget, input string name);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (got_q.size() < n) chk({name, "_timeout"}, got_q.size(), n);
  endtask

  task automatic push_impulse(input int v);
    stim_q.push_back(v);
    repeat (NT - 1) stim_q.push_back(0);
  endtask

  int sv[64];
  int run_a[8];
  int k;

  initial begin
    // Reset with data waiting: no pop may escape while reset is held.
    push_impulse(1024);
    repeat (3) @(posedge clk);
    #3 reset = 1;
    wait_outputs(4, 400, "impulse");
    chk("impulse_0", got_q[0], 24);
    chk("impulse_1", got_q[1], 90);
    chk("impulse_2", got_q[2], 36);
    chk("impulse_3", got_q[3], -2);

    do_reset();
    repeat (64) stim_q.push_back(1024);
    wait_outputs(8, 800, "dc");
    chk("dc_0", got_q[0], 32);
    chk("dc_1", got_q[1], 586);
    for (int i = 3; i < 8; i++) chk("dc_gain", got_q[i], 1172);

    chk("deq_neg1", longint'(audio_fir_pkg::dequantize(-64'sd1)), 0);
    chk("deq_neg2048", longint'(audio_fir_pkg::dequantize(-64'sd2048)), -2);
    do_reset();
    push_impulse(-1);
    wait_outputs(4, 400, "round_a");
    for (int i = 0; i < 4; i++) chk("round_neg1", got_q[i], 0);
    do_reset();
    push_impulse(-1025);
    wait_outputs(4, 400, "round_b");
    chk("round_b0", got_q[0], -24);
    chk("round_b1", got_q[1], -90);
    chk("round_b2", got_q[2], -36);
    chk("round_b3", got_q[3], 2);

    // Backpressure: hold OUTPUT for 20 cycles beyond the normal push point.
    do_reset();
    full_force = 1;
    repeat (16) stim_q.push_back(rand_sample());
    k = 0;
    while (!(busy && cyc >= pend_cyc + NT + 1 + 20) && k < 300) begin
      @(posedge clk); #2; k++;
    end
    chk("bp_held_no_output", got_q.size(), 0);
    full_force = 0;
    wait_outputs(2, 300, "bp");
    repeat (60) @(posedge clk);
    chk("bp_output_count", got_q.size(), 2);

    // Stalled input must give bit-identical outputs to the unstalled run.
    foreach (sv[i]) sv[i] = rand_sample();
    do_reset();
    stall_mode = 1;
    foreach (sv[i]) stim_q.push_back(sv[i]);
    wait_outputs(8, 2000, "stall");
    for (int i = 0; i < 8; i++) run_a[i] = (got_q.size() > i) ? got_q[i] : 0;
    do_reset();
    stall_mode = 0;
    foreach (sv[i]) stim_q.push_back(sv[i]);
    wait_outputs(8, 1000, "nostall");
    for (int i = 0; i < 8; i++) chk("stall_vs_nostall", run_a[i], (got_q.size() > i) ? got_q[i] : 0);

    // Reset at tap 10 of the second block, after a first block set audio_out.
    do_reset();
    repeat (16) stim_q.push_back(1024);
    k = 0;
    while (!(got_q.size() == 1 && busy && cyc - pend_cyc >= 11) && k < 300) begin
      @(posedge clk); #2; k++;
    end
    chk("midmac_first_out", (got_q.size() > 0) ? got_q[0] : 0, 32);
    reset = 0;
    #1;
    chk("midmac_audio_cleared", audio_out, 0);
    chk("midmac_no_wr", wr_en_out, 0);
    stim_q.delete();
    pop_flag = 0;
    repeat (2) @(posedge clk);
    repeat (8) stim_q.push_back(1024);
    #3 reset = 1;
    wait_outputs(1, 200, "midmac");
    repeat (60) @(posedge clk);
    chk("midmac_out_count", got_q.size(), 1);
    chk("midmac_partial_sum", (got_q.size() > 0) ? got_q[0] : 0, 32);

    do_reset();
    stall_mode = 2;
    full_rand = 1;
    repeat (160) stim_q.push_back(rand_sample());
    wait_outputs(20, 5000, "random");
    stall_mode = 0;
    full_rand = 0;

`ifdef AUDIO_FIR_SAT_EN
    do_reset();
    repeat (32) stim_q.push_back(32'h7FFF_FFFF);
    wait_outputs(4, 400, "sat");
    chk("sat_clamp", got_q[3], 32767);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d outputs expected completion", got_q.size());
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/audio_fir_decim.md
Name: audio_fir_decim

Overview:
- Audio low-pass FIR with integrated decimation; sits directly downstream of the FM demodulator stage.
- Pops Q10 demodulated samples from the demod output FIFO and keeps a TAPS-deep sample history.
- After every DECIM accepted samples, runs one multiply-accumulate per cycle over all taps, then pushes one filtered audio sample to the output FIFO.

Parameters:
- TAPS, 32, number of FIR taps; must be a multiple of DECIM.
- DECIM, 8, decimation factor; one output per DECIM inputs.
- QBITS, 10, fixed-point fraction bits for samples and coefficients.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- input_fifo_empty  in  1  demod FIFO empty flag.
- input_rd_en  out  1  pop strobe to demod FIFO; combinational.
- sample_in  in  32  signed Q10 demodulated sample; valid while input_fifo_empty=0.
- audio_out  out  32  signed Q10 filtered sample; registered.
- wr_en_out  out  1  push strobe to output FIFO; combinational.
- out_fifo_full  in  1  output FIFO full flag.

Behaviour:
- Reset (reset=0, asynchronous): state=ACCEPT; shift[0..TAPS-1]=0; dec_cnt=0; tap_idx=0; acc=0; audio_out=0; input_rd_en=0; wr_en_out=0.
- State ACCEPT:
  - If !input_fifo_empty: input_rd_en=1 that cycle; shift[0]<=sample_in; shift[i]<=shift[i-1]; dec_cnt increments.
  - If dec_cnt==DECIM-1 on a read: dec_cnt<=0, acc<=0, tap_idx<=0, go to MAC.
  - If the FIFO is empty: hold; no pop.
- State MAC:
  - One tap per cycle: acc<=acc + DEQUANTIZE(shift[tap_idx]*coef[tap_idx]).
  - After tap_idx==TAPS-1: load audio_out<=final acc, go to OUTPUT.
  - Occupies exactly TAPS cycles.
  - input_rd_en=0 throughout; upstream is back-pressured by its own FIFO.
- State OUTPUT:
  - If !out_fifo_full: wr_en_out=1 for one cycle; audio_out is already stable; return to ACCEPT.
  - Else: hold with wr_en_out=0; audio_out holds its value.
- Arithmetic:
  - Product: 32x32 signed to 64-bit.
  - DEQUANTIZE rounds toward zero: if negative, add (2^QBITS)-1, then arithmetic shift right by QBITS; truncate to 32 bits.
  - Accumulator: 32-bit signed, wraps on overflow unless the optional feature is enabled.
- Latency:
  - Last input pop of a block to wr_en_out: TAPS+1 cycles (TAPS MAC cycles, then OUTPUT), given out_fifo_full=0.
  - Minimum throughput: DECIM+TAPS+1 cycles per output.
- Boundaries:
  - Startup: the history starts at zero; the first output is produced after DECIM samples, not after TAPS samples.
  - No input is popped in MAC or OUTPUT.
  - dec_cnt wraps DECIM-1 to 0.
  - Reset asserted mid-MAC or mid-OUTPUT: history is discarded and no partial write is issued.
  - audio_out changes only when leaving MAC or on reset.

Optional Feature:
- Macro: AUDIO_FIR_SAT_EN.
- Defined: each accumulate saturates to the signed 32-bit range, and the final audio_out is clamped to [-32768, 32767] (16-bit audio range in Q10 counts).
- Undefined: accumulate wraps in 32 bits and audio_out is the raw accumulator.

Decomposition:
- Package audio_fir_pkg holds:
  - TAPS, DECIM and QBITS defaults;
  - the AUDIO_LPR_COEFFS constant array (TAPS x 32-bit signed Q10);
  - the DEQUANTIZE function;
  - state enum {ACCEPT, MAC, OUTPUT}.
- One natural sub-module: fir_mac_unit, covering the registered multiply, DEQUANTIZE and accumulate, with optional saturation.

Test Plan:
- Impulse: sample_in=1024 then 31 zeros, out_fifo_full=0 -> four outputs equal coef[7], coef[15], coef[23], coef[31], each pushed exactly TAPS+1 cycles after the 8th pop.
- DC: 64 samples of 1024 -> outputs 1..3 ramp; outputs 4..8 equal the sum of DEQUANTIZE(1024*coef[i]) over i=0..31, the Q10 DC gain.
- Rounding: coefficient set to 1, history holds -1 -> product -1 dequantizes to 0, not -1; a history of -2048 gives -2.
- Backpressure: hold out_fifo_full=1 for 20 cycles at OUTPUT -> wr_en_out=0 and no input_rd_en during the hold; a single wr_en_out pulse on release; no sample lost or duplicated.
- Empty stalls: toggle input_fifo_empty every other cycle -> input_rd_en only when empty=0; outputs bit-identical to the no-stall run.
- Reset mid-MAC: assert reset at tap_idx=10 -> all outputs 0 immediately, no wr_en_out; the next 8 samples of 1024 produce coef sum over i=0..7 only.
- With AUDIO_FIR_SAT_EN: 32 samples of 0x7FFFFFFF -> audio_out=32767.
